// File: rtl/n_to_1_wormhole_arbiter.sv
// n_to_1_wormhole_arbiter: N buffered inputs reduced to one output; priority grant with
// round-robin tie-break, wormhole lock from HEAD to TAIL, orphan BODY/TAIL discard.
module n_to_1_wormhole_arbiter #(
   parameter int N = 8,
   parameter int FLIT_SIZE = 32,
   parameter int HEADER_LEN = 2,
   parameter logic [HEADER_LEN-1:0] HEAD_FLIT = 2'b01,
   parameter logic [HEADER_LEN-1:0] BODY_FLIT = 2'b10,
   parameter logic [HEADER_LEN-1:0] TAIL_FLIT = 2'b11,
   parameter logic [HEADER_LEN-1:0] SINGLE_FLIT = 2'b00,
   parameter int CMP_POS = 29,
   parameter int CMP_LEN = 4,
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [FLIT_SIZE*N-1:0] in,
   input  logic [N-1:0]           in_valid,
   output logic [N-1:0]           in_avail,
   output logic [FLIT_SIZE-1:0]   out,
   output logic                   out_valid,
   input  logic                   out_avail,
   output logic                   drop_pulse,
   output logic                   lock_active
);
   localparam int AW = $clog2(DEPTH);
   localparam int CW = AW + 1;
   localparam int IW = $clog2(N);
   typedef enum logic {IDLE, LOCKED} state_t;
   state_t state_q, state_d;
   logic [IW-1:0] owner_q, owner_d, rr_ptr_q, rr_ptr_d, sel, idx, oi;
   logic [AW-1:0] wr_q [N];
   logic [AW-1:0] wr_d [N];
   logic [AW-1:0] rd_q [N];
   logic [AW-1:0] rd_d [N];
   logic [CW-1:0] cnt_q [N];
   logic [CW-1:0] cnt_d [N];
   logic [FLIT_SIZE-1:0] mem_q [N][DEPTH];
   logic [FLIT_SIZE-1:0] head [N];
   logic [HEADER_LEN-1:0] typ [N];
   logic [CMP_LEN-1:0] prio [N];
   logic [CMP_LEN-1:0] best;
   logic [N-1:0] push, pop, cand, orph;
   logic found, have_orph;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         head[i] = mem_q[i][rd_q[i]];
         typ[i] = head[i][FLIT_SIZE-1 -: HEADER_LEN];
         prio[i] = head[i][CMP_POS -: CMP_LEN];
         in_avail[i] = !rst && cnt_q[i] != CW'(DEPTH);
         push[i] = in_valid[i] && in_avail[i];
         cand[i] = cnt_q[i] != '0 && (typ[i] == HEAD_FLIT || typ[i] == SINGLE_FLIT);
         orph[i] = cnt_q[i] != '0 && (typ[i] == BODY_FLIT || typ[i] == TAIL_FLIT);
      end
   end

   always_comb begin
      state_d = state_q;
      owner_d = owner_q;
      rr_ptr_d = rr_ptr_q;
      sel = owner_q;
      idx = '0;
      best = '0;
      found = 1'b0;
      oi = '0;
      have_orph = 1'b0;
      pop = '0;
      drop_pulse = 1'b0;
      out_valid = 1'b0;
      if (state_q == IDLE) begin
         // strict '>' keeps the first tied candidate found scanning up from rr_ptr
         for (int k = 0; k < N; k++) begin
            idx = IW'((int'(rr_ptr_q) + k) % N);
            if (cand[idx] && (!found || prio[idx] > best)) begin
               found = 1'b1;
               best = prio[idx];
               sel = idx;
            end
         end
         for (int i = N - 1; i >= 0; i--)
            if (orph[i]) begin
               have_orph = 1'b1;
               oi = IW'(i);
            end
         out_valid = found;
         if (have_orph) begin
            pop[oi] = 1'b1;
            drop_pulse = 1'b1;
         end
         if (found && out_avail) begin
            pop[sel] = 1'b1;
            rr_ptr_d = (sel == IW'(N - 1)) ? '0 : sel + IW'(1);
            if (typ[sel] == HEAD_FLIT) begin
               state_d = LOCKED;
               owner_d = sel;
            end
         end
      end else begin
         out_valid = cnt_q[owner_q] != '0;
         if (out_valid && out_avail) begin
            pop[owner_q] = 1'b1;
            drop_pulse = typ[owner_q] == HEAD_FLIT || typ[owner_q] == SINGLE_FLIT;
            state_d = (typ[owner_q] == TAIL_FLIT) ? IDLE : LOCKED;
         end
      end
   end

   assign out = out_valid ? head[sel] : '0;
   assign lock_active = state_q == LOCKED;

   always_comb begin
      for (int i = 0; i < N; i++) begin
         wr_d[i] = wr_q[i] + AW'(push[i]);
         rd_d[i] = rd_q[i] + AW'(pop[i]);
         cnt_d[i] = cnt_q[i] + CW'(push[i]) - CW'(pop[i]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         owner_q <= '0;
         rr_ptr_q <= '0;
         for (int i = 0; i < N; i++) begin
            wr_q[i] <= '0;
            rd_q[i] <= '0;
            cnt_q[i] <= '0;
         end
      end else begin
         state_q <= state_d;
         owner_q <= owner_d;
         rr_ptr_q <= rr_ptr_d;
         for (int i = 0; i < N; i++) begin
            wr_q[i] <= wr_d[i];
            rd_q[i] <= rd_d[i];
            cnt_q[i] <= cnt_d[i];
         end
      end
   end

   always_ff @(posedge clk) begin
      for (int i = 0; i < N; i++)
         if (push[i]) mem_q[i][wr_q[i]] <= in[FLIT_SIZE*i +: FLIT_SIZE];
   end
endmodule

// File: tb/tb_n_to_1_wormhole_arbiter.sv
// tb_n_to_1_wormhole_arbiter: per-cycle vector table plus hand sequences for FIFO-full and
// mid-packet reset.
module tb_n_to_1_wormhole_arbiter;
   logic clk = 1'b0;
   logic rst;
   logic [255:0] in;
   logic [7:0] in_valid;
   logic [7:0] in_avail;
   logic [31:0] out;
   logic out_valid;
   logic out_avail;
   logic drop_pulse;
   logic lock_active;
   int passed = 0;
   int total = 0;

   n_to_1_wormhole_arbiter dut (
      .clk(clk), .rst(rst), .in(in), .in_valid(in_valid), .in_avail(in_avail),
      .out(out), .out_valid(out_valid), .out_avail(out_avail),
      .drop_pulse(drop_pulse), .lock_active(lock_active)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0]  vld;
      int          c0;
      logic [31:0] f0;
      int          c1;
      logic [31:0] f1;
      logic        ov;
      logic [31:0] o;
      logic        lk;
      logic        dr;
      logic [2:0]  rr;
   } row_t;

   row_t rows[$];

   function automatic logic [31:0] mk(input logic [1:0] t, input logic [3:0] p, input int x);
      return {t, p, 26'(x)};
   endfunction
   function automatic logic [31:0] fs(input logic [3:0] p, input int x); return mk(2'b00, p, x); endfunction
   function automatic logic [31:0] fh(input logic [3:0] p, input int x); return mk(2'b01, p, x); endfunction
   function automatic logic [31:0] fb(input int x); return mk(2'b10, 4'd0, x); endfunction
   function automatic logic [31:0] ft(input int x); return mk(2'b11, 4'd0, x); endfunction

   function automatic row_t r(input logic [7:0] vld, input int c0, input logic [31:0] f0,
                              input int c1, input logic [31:0] f1, input logic ov,
                              input logic [31:0] o, input logic lk, input logic dr,
                              input logic [2:0] rr);
      row_t x;
      x.vld = vld; x.c0 = c0; x.f0 = f0; x.c1 = c1; x.f1 = f1;
      x.ov = ov; x.o = o; x.lk = lk; x.dr = dr; x.rr = rr;
      return x;
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", nm, act, exp);
      else passed++;
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      in = '0;
      in_valid = '0;
      out_avail = 1'b1;
      #2;
      chk("reset in_avail", 32'(in_avail), 32'h0);
      chk("reset out_valid", 32'(out_valid), 32'h0);
      chk("reset out", out, 32'h0);
      chk("reset drop_pulse", 32'(drop_pulse), 32'h0);
      chk("reset lock_active", 32'(lock_active), 32'h0);
      next_cycle();
      next_cycle();
      rst = 1'b0;

      rows.push_back(r(8'h04, 2, fs(5, 1), 2, fs(5, 1), 0, 0, 0, 0, 0));
      rows.push_back(r(8'h00, 0, 0, 0, 0, 1, fs(5, 1), 0, 0, 0));
      rows.push_back(r(8'h03, 0, fh(3, 2), 1, fs(9, 3), 0, 0, 0, 0, 3));
      rows.push_back(r(8'h00, 0, 0, 0, 0, 1, fs(9, 3), 0, 0, 3));
      rows.push_back(r(8'h00, 0, 0, 0, 0, 1, fh(3, 2), 0, 0, 2));
      rows.push_back(r(8'h01, 0, ft(4), 0, ft(4), 0, 0, 1, 0, 1));
      rows.push_back(r(8'h00, 0, 0, 0, 0, 1, ft(4), 1, 0, 1));
      rows.push_back(r(8'h01, 0, fh(2, 5), 0, fh(2, 5), 0, 0, 0, 0, 1));
      rows.push_back(r(8'h09, 0, fb(7), 3, fh(15, 6), 1, fh(2, 5), 0, 0, 1));
      rows.push_back(r(8'h00, 0, 0, 0, 0, 1, fb(7), 1, 0, 1));
      rows.push_back(r(8'h00, 0, 0, 0, 0, 0, 0, 1, 0, 1));
      rows.push_back(r(8'h01, 0, ft(8), 0, ft(8), 0, 0, 1, 0, 1));
      rows.push_back(r(8'h00, 0, 0, 0, 0, 1, ft(8), 1, 0, 1));
      rows.push_back(r(8'h00, 0, 0, 0, 0, 1, fh(15, 6), 0, 0, 1));
      rows.push_back(r(8'h08, 3, ft(9), 3, ft(9), 0, 0, 1, 0, 4));
      rows.push_back(r(8'h00, 0, 0, 0, 0, 1, ft(9), 1, 0, 4));
      rows.push_back(r(8'h02, 1, fs(1, 10), 1, fs(1, 10), 0, 0, 0, 0, 4));
      rows.push_back(r(8'h00, 0, 0, 0, 0, 1, fs(1, 10), 0, 0, 4));
      rows.push_back(r(8'h0A, 1, fs(7, 11), 3, fs(7, 12), 0, 0, 0, 0, 2));
      rows.push_back(r(8'h00, 0, 0, 0, 0, 1, fs(7, 12), 0, 0, 2));
      rows.push_back(r(8'h00, 0, 0, 0, 0, 1, fs(7, 11), 0, 0, 4));
      rows.push_back(r(8'h80, 7, fs(0, 13), 7, fs(0, 13), 0, 0, 0, 0, 2));
      rows.push_back(r(8'h00, 0, 0, 0, 0, 1, fs(0, 13), 0, 0, 2));
      rows.push_back(r(8'h04, 2, fb(14), 2, fb(14), 0, 0, 0, 0, 0));
      rows.push_back(r(8'h00, 0, 0, 0, 0, 0, 0, 0, 1, 0));
      rows.push_back(r(8'h05, 0, fs(3, 16), 2, ft(15), 0, 0, 0, 0, 0));
      rows.push_back(r(8'h00, 0, 0, 0, 0, 1, fs(3, 16), 0, 1, 0));
      rows.push_back(r(8'h00, 0, 0, 0, 0, 0, 0, 0, 0, 1));

      foreach (rows[i]) begin
         in = '0;
         in[rows[i].c0*32 +: 32] = rows[i].f0;
         in[rows[i].c1*32 +: 32] = rows[i].f1;
         in_valid = rows[i].vld;
         @(negedge clk);
         chk($sformatf("row%0d out_valid", i), 32'(out_valid), 32'(rows[i].ov));
         if (rows[i].ov) chk($sformatf("row%0d out", i), out, rows[i].o);
         chk($sformatf("row%0d lock_active", i), 32'(lock_active), 32'(rows[i].lk));
         chk($sformatf("row%0d drop_pulse", i), 32'(drop_pulse), 32'(rows[i].dr));
         chk($sformatf("row%0d rr_ptr", i), 32'(dut.rr_ptr_q), 32'(rows[i].rr));
         chk($sformatf("row%0d in_avail", i), 32'(in_avail), 32'hFF);
         next_cycle();
      end

      out_avail = 1'b0;
      for (int k = 0; k < 5; k++) begin
         in = '0;
         in[31:0] = fs(1, 20 + k);
         in_valid = 8'h01;
         @(negedge clk);
         chk($sformatf("full k%0d in_avail0", k), 32'(in_avail[0]), (k < 4) ? 32'h1 : 32'h0);
         if (k > 0) chk($sformatf("full k%0d out held", k), out, fs(1, 20));
         next_cycle();
      end
      in_valid = '0;
      out_avail = 1'b1;
      @(negedge clk);
      chk("full pop out", out, fs(1, 20));
      chk("full pop in_avail0", 32'(in_avail[0]), 32'h0);
      next_cycle();
      out_avail = 1'b0;
      @(negedge clk);
      chk("after pop in_avail0", 32'(in_avail[0]), 32'h1);
      chk("after pop out", out, fs(1, 21));
      next_cycle();
      out_avail = 1'b1;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         chk($sformatf("drain%0d out", k), out, fs(1, 21 + k));
         next_cycle();
      end
      @(negedge clk);
      chk("drain fifth not kept", 32'(out_valid), 32'h0);
      next_cycle();

      in[31:0] = fh(4, 30);
      in_valid = 8'h01;
      next_cycle();
      in_valid = '0;
      @(negedge clk);
      chk("rst seq head out", out, fh(4, 30));
      next_cycle();
      in[31:0] = fb(31);
      in_valid = 8'h01;
      out_avail = 1'b0;
      @(negedge clk);
      chk("rst seq locked", 32'(lock_active), 32'h1);
      next_cycle();
      in_valid = '0;
      @(negedge clk);
      chk("rst seq body pending", out, fb(31));
      #1;
      rst = 1'b1;
      #1;
      chk("mid rst out_valid", 32'(out_valid), 32'h0);
      chk("mid rst lock_active", 32'(lock_active), 32'h0);
      chk("mid rst out", out, 32'h0);
      chk("mid rst in_avail", 32'(in_avail), 32'h0);
      next_cycle();
      rst = 1'b0;
      out_avail = 1'b1;
      @(negedge clk);
      chk("post rst out_valid", 32'(out_valid), 32'h0);
      chk("post rst in_avail", 32'(in_avail), 32'hFF);
      chk("post rst lock_active", 32'(lock_active), 32'h0);
      next_cycle();
      @(negedge clk);
      chk("post rst body gone", 32'(out_valid), 32'h0);
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
